demux1_n_reg: RTL
=================

DEMUX1_N_REG -- requirements
Module: demux1_n_reg

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DW, 8, data width in bits, >=1.
- NCH, 4, output channel count; power of two, >=2.
- SELW, $clog2(NCH), select width; derived, never overridden.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  input word accepted this cycle when high with in_valid.
- in_sel  in  SELW  destination channel.
- in_data  in  DW  input word.
- out_valid  out  NCH  bit k: channel k holds a word.
- out_ready  in  NCH  bit k: consumer k takes the word this cycle.
- out_data  out  NCH*DW  channel k word at bits [k*DW +: DW].
- ch_count  out  NCH*16  present only with DEMUX1_N_CNT_EN (REQ-018).

Function
REQ-003 Each channel SHALL hold a one-entry slot, state EMPTY or FULL.
REQ-004 Transfer in: in_valid && in_ready writes in_data to slot in_sel at the clock edge.
REQ-005 Transfer out on channel k: out_valid[k] && out_ready[k]; the slot empties unless refilled the same cycle.
REQ-006 in_ready SHALL equal !FULL[in_sel] || out_ready[in_sel], combinationally; it does not depend on in_valid.
REQ-007 Latency SHALL be exactly one cycle from accepted input to out_valid[in_sel] high.
REQ-008 Slot transitions:
- EMPTY->FULL on write.
- FULL->EMPTY on drain without write.
- FULL->FULL on simultaneous drain+write, with the new word loaded.
- FULL->FULL with data held on neither event.
REQ-009 Channels other than in_sel SHALL be unaffected by the write; each drains independently.
REQ-010 out_data[k] SHALL hold its last value while EMPTY and SHALL change only on a write to k.
REQ-011 At most one channel SHALL be written per cycle; several channels MAY drain in the same cycle.
REQ-012 When in_valid is low, in_sel and in_data SHALL be ignored and no state SHALL change except drains.
REQ-013 out_valid SHALL come directly from slot state registers, with no combinational path from in_* to out_*.
REQ-014 A word SHALL never be lost or duplicated: every accepted word appears exactly once on its channel.

Reset
REQ-015 While rst_n is low, regardless of clk: all slots EMPTY, out_valid=0, out_data=0, ch_count=0.
REQ-016 Reset assertion mid-operation SHALL discard held words. in_ready SHALL read 1 during reset (all slots EMPTY).
REQ-017 Reset deassertion SHALL be synchronised by the integrator. The first transfer MAY occur on the first rising edge after deassertion.

Configuration
REQ-018 With macro DEMUX1_N_CNT_EN defined:
- port ch_count exists.
- field k, bits [k*16 +: 16], counts accepted writes to channel k.
- counter wraps 0xFFFF->0x0000 without saturation.
- a drain does not change the count.
REQ-019 Without DEMUX1_N_CNT_EN: no port ch_count, no counter logic; all other behaviour identical.

Structure
REQ-020 Shared package demux_pkg SHALL hold:
- the slot state typedef (EMPTY, FULL).
- the counter width constant CNT_W=16.
- the default DW and NCH constants.
REQ-021 Sub-module demux_slot (one-entry buffer: wr, rd, data in/out, valid, optional counter) SHALL be instantiated NCH times via a generate loop. demux1_n_reg holds only select decode and the in_ready mux.

Verification
REQ-022 The bench SHALL cover, at NCH=4, DW=8 unless stated:
- Sweep: sel 0..3 with data 0xA0..0xA3, all out_ready=1 -> each out_valid[k] pulses one cycle after its write with data 0xA0+k; in_ready stays 1.
- Backpressure: out_ready[2]=0, two writes to sel 2 (0x11, 0x22) -> first accepted, in_ready=0 on second; out_data[2]=0x11 held. Raise out_ready[2] -> 0x22 accepted that cycle, 0x11 drained, 0x22 visible next cycle.
- Independence: channel 1 FULL and stalled, write 0x55 to sel 3 -> accepted; out_valid=4'b1010.
- Reset mid-operation: channels 0 and 3 FULL, pulse rst_n low between edges -> out_valid=0, out_data=0 immediately, in_ready=1.
- Wrap (DEMUX1_N_CNT_EN): 65537 writes to sel 0 -> ch_count[15:0]=1, other fields 0.
- Parametrised: NCH=8, DW=16, write 0xBEEF to sel 7 -> out_data[127:112]=0xBEEF, out_valid=8'h80.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1:N demultiplexer.
//
// Contents:
//   slot_state_e  one-entry slot occupancy (EMPTY / FULL)
//   CNT_W         width of each per-channel write counter
//   DEF_DW        default data width
//   DEF_NCH       default channel count
//   ch_field_lsb  LSB of channel k inside a packed per-channel bus
//
// The per-channel write counters are built only when DEMUX1_N_CNT_EN is
// defined; CNT_W is still declared here so both builds share one package.
package demux_pkg;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned DEF_DW  = 8;
  localparam int unsigned DEF_NCH = 4;

  // Slot occupancy; EMPTY encodes as 0 so reset and "no word" coincide.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  // Bit position of channel k's field inside a flattened NCH*W bus.
  function automatic int unsigned ch_field_lsb(input int unsigned k,
                                               input int unsigned w);
    return k * w;
  endfunction

endpackage : demux_pkg

// File: rtl/demux_slot.sv
// One-entry output buffer for a single demux channel.
//
// Parameters:
//   DW        data width
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   wr        load wr_data this cycle (already qualified by the parent's
//             in_ready, so a write never overwrites an undrained word)
//   rd        consumer ready; only takes effect while the slot is FULL
//   wr_data   word to load
//   rd_data   held word; keeps its value while EMPTY, changes only on wr
//   valid     slot is FULL (decoded straight from the state register)
//   count     writes accepted since reset, wraps at 2**CNT_W
//             (only with DEMUX1_N_CNT_EN)
//
// Optional feature macro: DEMUX1_N_CNT_EN
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             rd,
  input  logic [DW-1:0]    wr_data,
  output logic [DW-1:0]    rd_data,
  output logic             valid
`ifdef DEMUX1_N_CNT_EN
  ,
  output logic [CNT_W-1:0] count
`endif
);

  slot_state_e state;
  logic        drain;

  // A drain only exists when there is a word to hand over.
  assign drain = (state == FULL) && rd;

  // Slot state and data; a write wins over a drain, which covers the
  // simultaneous drain+refill case (stay FULL with the new word).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      rd_data <= '0;
    end else begin
      if (wr) begin
        state   <= FULL;
        rd_data <= wr_data;
      end else if (drain) begin
        state   <= EMPTY;
      end
    end
  end

  assign valid = (state == FULL);

`ifdef DEMUX1_N_CNT_EN
  // Accepted-write counter; free-running wrap, drains do not touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (wr) begin
      count <= count + CNT_W'(1);
    end
  end
`endif

endmodule : demux_slot

// File: rtl/demux1_n_reg.sv
// Registered 1:N demultiplexer with a one-entry buffer per output channel.
//
// A word offered on in_* is steered to channel in_sel and appears on that
// channel's out_valid/out_data one cycle after acceptance. Each channel
// drains independently through its own out_valid/out_ready handshake.
// in_ready is combinational: the addressed slot is empty or is being
// drained this cycle. out_* come only from slot registers.
//
// Parameters:
//   DW        data width (>= 1)
//   NCH       channel count (power of two, >= 2)
//   SELW      select width, derived from NCH
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input word present
//   in_ready   input word accepted when high together with in_valid
//   in_sel     destination channel
//   in_data    input word
//   out_valid  bit k: channel k holds a word
//   out_ready  bit k: consumer k takes the word this cycle
//   out_data   channel k word at [k*DW +: DW]
//   ch_count   channel k accepted-write count at [k*CNT_W +: CNT_W]
//              (only with DEMUX1_N_CNT_EN)
//
// Optional feature macro: DEMUX1_N_CNT_EN
module demux1_n_reg
  import demux_pkg::*;
#(
  parameter  int unsigned DW   = DEF_DW,
  parameter  int unsigned NCH  = DEF_NCH,
  localparam int unsigned SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SELW-1:0]      in_sel,
  input  logic [DW-1:0]        in_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [NCH*DW-1:0]    out_data
`ifdef DEMUX1_N_CNT_EN
  ,
  output logic [NCH*CNT_W-1:0] ch_count
`endif
);

  logic [NCH-1:0] wr_vec;
  logic           accept;

  // Addressed slot can take a word if empty or being emptied right now.
  assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
  assign accept   = in_valid && in_ready;

  // One-hot write strobe; with in_valid low nothing is written.
  always_comb begin
    wr_vec = '0;
    if (accept) begin
      wr_vec[in_sel] = 1'b1;
    end
  end

  // One buffer per channel; every slot sees in_data, only the strobed one loads.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    demux_slot #(
      .DW (DW)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (wr_vec[k]),
      .rd      (out_ready[k]),
      .wr_data (in_data),
      .rd_data (out_data[ch_field_lsb(k, DW) +: DW]),
      .valid   (out_valid[k])
`ifdef DEMUX1_N_CNT_EN
      ,
      .count   (ch_count[ch_field_lsb(k, CNT_W) +: CNT_W])
`endif
    );
  end

endmodule : demux1_n_reg
